// File: rtl/alarm_pkg.sv
// Shared widths, FSM state encoding and small helpers for the alarm arm/disarm sequencer.
package alarm_pkg;

  localparam int unsigned CODE_W  = 10;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned FAIL_W  = 3;
  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_DISARMED    = 3'd0,
    ST_EXIT_DELAY  = 3'd1,
    ST_ARMED       = 3'd2,
    ST_ENTRY_DELAY = 3'd3,
    ST_ALARM       = 3'd4,
    ST_LOCKOUT     = 3'd5
  } state_e;

  function automatic logic is_timed(input state_e s);
    return (s == ST_EXIT_DELAY) || (s == ST_ENTRY_DELAY) || (s == ST_LOCKOUT);
  endfunction

  function automatic logic video_on(input state_e s);
    return (s == ST_ENTRY_DELAY) || (s == ST_ALARM) || (s == ST_LOCKOUT);
  endfunction

endpackage

// File: rtl/sense_debounce.sv
// Two-flop synchroniser for the raw IR sensor followed by a stable-sample debounce filter.
module sense_debounce #(
  parameter int unsigned DEB_CYCLES = 500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic sense_raw,
  output logic sense_ok
);

  localparam int unsigned DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic          sync_q1;
  logic          sync_q2;
  logic [DW-1:0] stable_cnt;

  // sense_ok only follows the synchronised input after DEB_CYCLES consecutive differing samples
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q1    <= 1'b0;
      sync_q2    <= 1'b0;
      sense_ok   <= 1'b0;
      stable_cnt <= '0;
    end else begin
      sync_q1 <= sense_raw;
      sync_q2 <= sync_q1;
      if (sync_q2 == sense_ok) begin
        stable_cnt <= '0;
      end else if (stable_cnt == DW'(DEB_CYCLES - 1)) begin
        sense_ok   <= sync_q2;
        stable_cnt <= '0;
      end else begin
        stable_cnt <= stable_cnt + DW'(1);
      end
    end
  end

endmodule

// File: rtl/alarm_arm_ctrl.sv
// Alarm sequencer: disarmed -> exit delay -> armed -> entry delay -> alarm, with passcode and lockout.
module alarm_arm_ctrl
  import alarm_pkg::*;
#(
  parameter int unsigned CLK_FREQ     = 50_000_000,
  parameter int unsigned EXIT_S       = 10,
  parameter int unsigned ENTRY_S      = 15,
  parameter int unsigned LOCK_S       = 30,
  parameter int unsigned MAX_FAILS    = 3,
  parameter int unsigned DEB_CYCLES   = 500_000,
  parameter logic [9:0]  DEFAULT_CODE = 10'h112
) (
  input  logic               iCLK,
  input  logic               iRST,
  input  logic               iSENSE,
  input  logic [CODE_W-1:0]  iCODE,
  input  logic               iSET_CODE,
  input  logic               iARM,
  input  logic               iDISARM,
  output logic               oVideo_On,
  output logic               oBuzzer,
  output logic [STATE_W-1:0] oState,
  output logic [CNT_W-1:0]   oCountdown,
  output logic [FAIL_W-1:0]  oFails
);

  localparam int unsigned PW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;

  state_e             state;
  state_e             nxt_state;
  logic [CODE_W-1:0]  code;
  logic [PW-1:0]      presc;
  logic [CNT_W-1:0]   countdown;
  logic [FAIL_W-1:0]  fails;
  logic [FAIL_W:0]    fails_inc;
  logic               buzz_ph;
  logic               sense_ok;
  logic [2:0]         keys_q;
  logic [2:0]         keys_qq;
  logic [2:0]         key_edge;
  logic               tick;
  logic               expire;
  logic               keys_live;
  logic               disarm_ok;
  logic               disarm_bad;
  logic               lock_now;
  logic               state_chg;

  sense_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_sense_debounce (
    .clk      (iCLK),
    .rst      (iRST),
    .sense_raw(iSENSE),
    .sense_ok (sense_ok)
  );

  function automatic logic [CNT_W-1:0] load_cnt(input state_e s);
    case (s)
      ST_EXIT_DELAY:  return CNT_W'(EXIT_S);
      ST_ENTRY_DELAY: return CNT_W'(ENTRY_S);
      ST_LOCKOUT:     return CNT_W'(LOCK_S);
      default:        return '0;
    endcase
  endfunction

  // key_edge bits: [2]=set, [1]=arm, [0]=disarm
  always_comb begin
    key_edge   = keys_q & ~keys_qq;
    tick       = (presc == PW'(CLK_FREQ - 1));
    expire     = tick && (countdown == CNT_W'(1));
    keys_live  = (state != ST_DISARMED) && (state != ST_LOCKOUT);
    disarm_ok  = key_edge[0] && keys_live && (iCODE == code);
    disarm_bad = key_edge[0] && keys_live && (iCODE != code);
    fails_inc  = {1'b0, fails} + (FAIL_W + 1)'(1);
    lock_now   = disarm_bad && (fails_inc >= (FAIL_W + 1)'(MAX_FAILS));

    nxt_state = state;
    if (disarm_ok) begin
      nxt_state = ST_DISARMED;
    end else if (lock_now) begin
      nxt_state = ST_LOCKOUT;
    end else begin
      case (state)
        ST_DISARMED:    if (key_edge[1]) nxt_state = ST_EXIT_DELAY;
        ST_EXIT_DELAY:  if (expire)      nxt_state = ST_ARMED;
        ST_ARMED:       if (sense_ok)    nxt_state = ST_ENTRY_DELAY;
        ST_ENTRY_DELAY: if (expire)      nxt_state = ST_ALARM;
        ST_ALARM:       nxt_state = ST_ALARM;
        ST_LOCKOUT:     if (expire)      nxt_state = ST_ALARM;
        default:        nxt_state = ST_DISARMED;
      endcase
    end
    state_chg = (nxt_state != state);
  end

  // State, timers, code store and registered outputs (outputs trail the state register by one cycle)
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state      <= ST_DISARMED;
      code       <= CODE_W'(DEFAULT_CODE);
      presc      <= '0;
      countdown  <= '0;
      fails      <= '0;
      buzz_ph    <= 1'b0;
      keys_q     <= '0;
      keys_qq    <= '0;
      oVideo_On  <= 1'b0;
      oBuzzer    <= 1'b0;
      oState     <= '0;
      oCountdown <= '0;
      oFails     <= '0;
    end else begin
      keys_q  <= {iSET_CODE, iARM, iDISARM};
      keys_qq <= keys_q;

      if (state_chg) begin
        state     <= nxt_state;
        presc     <= '0;
        countdown <= load_cnt(nxt_state);
        buzz_ph   <= 1'b1;
      end else begin
        presc <= tick ? '0 : presc + PW'(1);
        if (tick && (countdown != '0)) countdown <= countdown - CNT_W'(1);
        if (tick && (state == ST_ENTRY_DELAY)) buzz_ph <= ~buzz_ph;
      end

      if (disarm_ok || ((state == ST_LOCKOUT) && expire)) begin
        fails <= '0;
      end else if (disarm_bad && (fails != FAIL_W'(MAX_FAILS))) begin
        fails <= fails + FAIL_W'(1);
      end

      if ((state == ST_DISARMED) && key_edge[2] && !key_edge[1]) code <= iCODE;

      oState     <= state;
      oCountdown <= is_timed(state) ? countdown : '0;
      oVideo_On  <= video_on(state);
      oBuzzer    <= (state == ST_ALARM) || (state == ST_LOCKOUT) ||
                    ((state == ST_ENTRY_DELAY) && buzz_ph);
      oFails     <= fails;
    end
  end

endmodule

// File: tb/tb_alarm_arm_ctrl.sv
// Scoreboard bench: stimulus queues expected output events, a monitor pops one per observed output change.
module tb_alarm_arm_ctrl;
  import alarm_pkg::*;

  logic       clk = 1'b0;
  logic       iRST = 1'b1;
  logic       iSENSE = 1'b0;
  logic [9:0] iCODE = 10'h112;
  logic       iSET_CODE = 1'b0;
  logic       iARM = 1'b0;
  logic       iDISARM = 1'b0;
  logic       oVideo_On;
  logic       oBuzzer;
  logic [2:0] oState;
  logic [7:0] oCountdown;
  logic [2:0] oFails;

  always #5 clk = ~clk;

  alarm_arm_ctrl #(
    .CLK_FREQ(10), .EXIT_S(2), .ENTRY_S(3), .LOCK_S(4),
    .MAX_FAILS(3), .DEB_CYCLES(4), .DEFAULT_CODE(10'h112)
  ) dut (
    .iCLK(clk), .iRST(iRST), .iSENSE(iSENSE), .iCODE(iCODE),
    .iSET_CODE(iSET_CODE), .iARM(iARM), .iDISARM(iDISARM),
    .oVideo_On(oVideo_On), .oBuzzer(oBuzzer), .oState(oState),
    .oCountdown(oCountdown), .oFails(oFails)
  );

  typedef struct {
    int st; int vid; int bz; int fl; int cd; int dl;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  bit   mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic push(input int st, input int vid, input int bz, input int fl, input int cd, input int dl);
    exp_t e;
    e.st = st; e.vid = vid; e.bz = bz; e.fl = fl; e.cd = cd; e.dl = dl;
    exp_q.push_back(e);
  endtask

  // Monitor: any change of {state, video, buzzer, fails} is one DUT event
  initial begin
    logic [7:0] last_vec;
    logic [7:0] cur_vec;
    int         last_cyc;
    int         evt;
    exp_t       e;
    evt = 0;
    last_vec = '0;
    last_cyc = 0;
    forever begin
      @(negedge clk);
      cur_vec = {oState, oVideo_On, oBuzzer, oFails};
      if (!mon_en) begin
        last_vec = cur_vec;
        last_cyc = cyc;
      end else if (cur_vec !== last_vec) begin
        evt++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL evt%0d_unexpected: state=%0d video=%0d buzzer=%0d fails=%0d, required no change",
                   evt, oState, oVideo_On, oBuzzer, oFails);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("evt%0d_state", evt), 32'(oState), e.st);
          chk($sformatf("evt%0d_video", evt), 32'(oVideo_On), e.vid);
          chk($sformatf("evt%0d_buzzer", evt), 32'(oBuzzer), e.bz);
          chk($sformatf("evt%0d_fails", evt), 32'(oFails), e.fl);
          if (e.cd >= 0) chk($sformatf("evt%0d_countdown", evt), 32'(oCountdown), e.cd);
          if (e.dl >= 0) chk($sformatf("evt%0d_delay", evt), cyc - last_cyc, e.dl);
        end
        last_vec = cur_vec;
        last_cyc = cyc;
      end
    end
  end

  task automatic wait_empty(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL timeout_%s: %0d events pending after %0d cycles, required 0", name, exp_q.size(), n);
      exp_q.delete();
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // which: 0=arm 1=disarm 2=set; raised now, one cycle high, one cycle low
  task automatic pulse(input int which);
    case (which)
      0: iARM = 1'b1;
      1: iDISARM = 1'b1;
      default: iSET_CODE = 1'b1;
    endcase
    @(posedge clk); #1;
    iARM = 1'b0; iDISARM = 1'b0; iSET_CODE = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic sense_for(input int n);
    iSENSE = 1'b1;
    idle(n);
    iSENSE = 1'b0;
  endtask

  task automatic arm_to_armed(input string name);
    push(ST_EXIT_DELAY, 0, 0, 0, 2, -1);
    push(ST_ARMED, 0, 0, 0, 0, 20);
    pulse(0);
    wait_empty(name, 40);
  endtask

  task automatic intrude_to_alarm(input string name);
    push(ST_ENTRY_DELAY, 1, 1, 0, 3, -1);
    push(ST_ENTRY_DELAY, 1, 0, 0, 2, 10);
    push(ST_ENTRY_DELAY, 1, 1, 0, 1, 10);
    push(ST_ALARM, 1, 1, 0, 0, 10);
    sense_for(5);
    wait_empty(name, 60);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset values
    idle(3);
    chk("rst_state", 32'(oState), 0);
    chk("rst_video", 32'(oVideo_On), 0);
    chk("rst_buzzer", 32'(oBuzzer), 0);
    chk("rst_fails", 32'(oFails), 0);
    chk("rst_countdown", 32'(oCountdown), 0);
    iRST = 1'b0;
    idle(2);
    mon_en = 1'b1;
    idle(1);

    // Arm with a sense pulse during exit delay that must be ignored
    push(ST_EXIT_DELAY, 0, 0, 0, 2, -1);
    push(ST_ARMED, 0, 0, 0, 0, 20);
    pulse(0);
    sense_for(6);
    wait_empty("arm", 40);

    // Glitch shorter than the debounce window
    sense_for(3);
    idle(15);
    chk("glitch_state", 32'(oState), ST_ARMED);
    chk("glitch_video", 32'(oVideo_On), 0);

    // Intrusion -> entry delay -> alarm, then valid disarm
    intrude_to_alarm("intrusion");
    push(ST_DISARMED, 0, 0, 0, 0, -1);
    pulse(1);
    wait_empty("disarm_alarm", 10);

    // Three wrong codes in entry delay -> lockout; keys ignored; expiry -> alarm with fails cleared
    arm_to_armed("arm2");
    push(ST_ENTRY_DELAY, 1, 1, 0, 3, -1);
    sense_for(5);
    wait_empty("entry2", 20);
    iCODE = 10'h000;
    push(ST_ENTRY_DELAY, 1, 1, 1, -1, -1);
    push(ST_ENTRY_DELAY, 1, 1, 2, -1, -1);
    push(ST_LOCKOUT, 1, 1, 3, 4, -1);
    push(ST_ALARM, 1, 1, 0, 0, 40);
    pulse(1);
    pulse(1);
    pulse(1);
    iCODE = 10'h2AA;
    pulse(2);
    iCODE = 10'h112;
    pulse(1);
    pulse(0);
    wait_empty("lockout", 60);
    push(ST_DISARMED, 0, 0, 0, 0, -1);
    pulse(1);
    wait_empty("disarm_after_lock", 10);

    // Change code; old code is now a failure, new code disarms even with simultaneous sense
    iCODE = 10'h3FF;
    pulse(2);
    arm_to_armed("arm3");
    iCODE = 10'h112;
    push(ST_ARMED, 0, 0, 1, 0, -1);
    pulse(1);
    wait_empty("old_code_fail", 10);
    iCODE = 10'h3FF;
    push(ST_DISARMED, 0, 0, 0, 0, -1);
    iSENSE = 1'b1;
    idle(5);
    iDISARM = 1'b1;
    idle(1);
    iDISARM = 1'b0;
    wait_empty("disarm_vs_sense", 10);
    iSENSE = 1'b0;
    idle(12);

    // Reset mid-alarm restores the default code
    arm_to_armed("arm4");
    intrude_to_alarm("intrusion2");
    push(ST_DISARMED, 0, 0, 0, 0, -1);
    iRST = 1'b1;
    idle(1);
    iRST = 1'b0;
    wait_empty("reset_mid_alarm", 5);
    chk("post_rst_countdown", 32'(oCountdown), 0);
    push(ST_EXIT_DELAY, 0, 0, 0, 2, -1);
    pulse(0);
    wait_empty("arm5", 10);
    push(ST_EXIT_DELAY, 0, 0, 1, -1, -1);
    pulse(1);
    wait_empty("stale_code_fail", 10);
    iCODE = 10'h112;
    push(ST_DISARMED, 0, 0, 0, 0, -1);
    pulse(1);
    wait_empty("default_code_disarm", 10);

    idle(5);
    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
